lms_adapt_ctrl: RTL and testbench
=================================

# lms_adapt_ctrl

Sequencing controller for the LMS adaptive filter datapath.
- Enables the filter and tracks which cycles carry a valid error from the error calculator (fixed LAT-cycle pipeline).
- Gates the coefficient-update engine to exactly those cycles.
- Schedules the step-size shift from windowed mean absolute error: coarse steps while acquiring, finest step once converged.
- Sits between the top-level control and the filter / error_calcu / weight-update blocks.

## Interface
- LAT, 9: cycles from an accepted sample (sample_valid_i while filt_en_o) to its error on error_i.
- WIN_LOG2, 6: log2 of errors per measurement window (64).
- MU_INIT, 4: initial step-size right-shift.
- MU_MAX, 10: finest step-size right-shift.
- TH_LOCK, 256: mean |error| below which the window counts as converged.
- TH_UNLOCK, 1024: mean |error| above which TRACK is abandoned.
- clk_i  in  1  system clock; single clock domain.
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse to begin adaptation; honoured in IDLE only.
- stop_i  in  1  return to IDLE; accepted in any state.
- sample_valid_i  in  1  new input sample presented to the filter this cycle.
- error_i  in  16 signed  error from the error calculator.
- filt_en_o  out  1  filter/datapath enable.
- wupd_en_o  out  1  coefficient update strobe; aligned with the valid error_i.
- mu_shift_o  out  4  step-size right-shift applied by the update engine.
- err_mean_o  out  16  mean |error| of the last completed window.
- converged_o  out  1  high while in TRACK.
- state_o  out  2  IDLE=0, FILL=1, ADAPT=2, TRACK=3.

## Operation
- Valid pipeline: LAT-bit shift register. Input is sample_valid_i & filt_en_o. Tap err_v is high in cycle t+LAT for a sample accepted in cycle t. Cleared in IDLE.
- wupd_en_o = err_v & (state ADAPT or TRACK). Decoded from registers only; no combinational path from any input.
- IDLE: filt_en_o=0, wupd_en_o=0, accumulator and window counter cleared. start_i -> FILL, mu_shift_o<=MU_INIT.
- FILL: filt_en_o=1; a cycle counter runs LAT cycles, then -> ADAPT.
- ADAPT and TRACK: on each err_v, acc += |error_i|.
  - |-32768| saturates to 32767.
  - acc is 16+WIN_LOG2 bits and never overflows.
  - The window counter increments on each err_v.
- Window end (the 2^WIN_LOG2-th err_v, its own error included):
  - err_mean_o <= acc_total >> WIN_LOG2.
  - acc and the counter restart at 0.
  - The decision below uses the new mean in the same update.
- ADAPT decision:
  - mean < TH_LOCK and mu < MU_MAX: mu+1.
  - mean < TH_LOCK and mu == MU_MAX: -> TRACK, converged_o=1.
  - Otherwise mu is held.
- TRACK decision: mean > TH_UNLOCK -> ADAPT, mu<=MU_INIT, converged_o=0. Otherwise hold.
- stop_i in any state -> IDLE next cycle. Outputs go to their reset values except err_mean_o, which holds. stop_i beats start_i and a simultaneous window end.
- start_i outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE
  - filt_en_o, wupd_en_o, converged_o: 0
  - mu_shift_o = MU_INIT
  - err_mean_o = 0
- start_i sampled at edge 0:
  - state_o=1 and filt_en_o=1 from cycle 1.
  - state_o=2 from cycle 1+LAT (cycle 10).
  - The first sample accepted in cycle 1 gives wupd_en_o in cycle 10.
- Window result: err_mean_o, mu_shift_o, state_o and converged_o all update on the edge after the final err_v cycle, all together.
- Valid samples may be back-to-back or sparse; no throughput limit.
- Reset mid-operation: all registers return to reset values immediately (async). Samples in flight are discarded.

## Test plan
- Reset, then idle 20 cycles: all outputs at reset values, state_o=0, wupd_en_o never high.
- start_i at cycle 0, sample_valid_i every cycle:
  - filt_en_o rises cycle 1.
  - state_o=2 and first wupd_en_o at cycle 10.
  - wupd_en_o continuous thereafter.
- error_i=100 constant from ADAPT entry:
  - mu_shift_o steps 4→10 at each window end (64 errors per window).
  - After the 7th window: state_o=3, converged_o=1, err_mean_o=100.
- In TRACK, drive error_i=-2000 for 64 errors: err_mean_o=2000, state_o=2, mu_shift_o=4, converged_o=0.
- error_i=-32768 for one full window in ADAPT: err_mean_o=32767, mu_shift_o unchanged.
- Timing collisions:
  - stop_i in the same cycle as the 64th err_v: next cycle state_o=0, err_mean_o unchanged, mu_shift_o=4.
  - start_i during ADAPT: ignored.

Source files
------------

// File: rtl/lms_adapt_ctrl.sv
// lms_adapt_ctrl: sequencing controller for the LMS adaptive filter.
// Tracks valid errors through the fixed-latency error pipeline, gates the
// coefficient update to those cycles and schedules the step-size shift
// from the windowed mean absolute error.
module lms_adapt_ctrl #(
  parameter int DATA_W    = 16,
  parameter int LAT       = 9,
  parameter int WIN_LOG2  = 6,
  parameter int MU_INIT   = 4,
  parameter int MU_MAX    = 10,
  parameter int TH_LOCK   = 256,
  parameter int TH_UNLOCK = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     sample_valid_i,
  input  logic signed [DATA_W-1:0] error_i,
  output logic                     filt_en_o,
  output logic                     wupd_en_o,
  output logic [3:0]               mu_shift_o,
  output logic [DATA_W-1:0]        err_mean_o,
  output logic                     converged_o,
  output logic [1:0]               state_o
);

  localparam int ACC_W  = DATA_W + WIN_LOG2;
  localparam int FILL_W = $clog2(LAT + 1);
  localparam logic [3:0]        MU_INIT_V   = 4'(MU_INIT);
  localparam logic [3:0]        MU_MAX_V    = 4'(MU_MAX);
  localparam logic [DATA_W-1:0] TH_LOCK_V   = DATA_W'(TH_LOCK);
  localparam logic [DATA_W-1:0] TH_UNLOCK_V = DATA_W'(TH_UNLOCK);
  localparam logic [FILL_W-1:0] FILL_LAST   = FILL_W'(LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, ADAPT = 2'd2, TRACK = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [LAT-1:0]      err_vld_sr;
  logic [FILL_W-1:0]   fill_cnt_q;
  logic [ACC_W-1:0]    acc_q;
  logic [WIN_LOG2-1:0] win_cnt_q;
  logic [3:0]          mu_q, mu_d;
  logic [DATA_W-1:0]   err_mean_q, err_mean_d;

  logic                err_v;
  logic                acc_en;
  logic                win_end;
  logic [ACC_W-1:0]    acc_total;
  logic [DATA_W-1:0]   mean_new;

  // |x| with the most negative code saturated to the largest positive value
  function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] neg;
    if (x == {1'b1, {(DATA_W-1){1'b0}}}) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
    neg = -x;
    return (x < 0) ? $unsigned(neg) : $unsigned(x);
  endfunction

  assign err_v     = err_vld_sr[LAT-1];
  assign acc_en    = err_v && (state_q == ADAPT || state_q == TRACK);
  assign acc_total = acc_q + ACC_W'(abs_sat(error_i));
  assign mean_new  = acc_total[ACC_W-1:WIN_LOG2];
  assign win_end   = acc_en && (win_cnt_q == '1);

  assign filt_en_o   = (state_q != IDLE);
  assign wupd_en_o   = acc_en;
  assign converged_o = (state_q == TRACK);
  assign state_o     = state_q;
  assign mu_shift_o  = mu_q;
  assign err_mean_o  = err_mean_q;

  // Next-state, step-size and window-result decisions; stop overrides all
  always_comb begin
    state_d    = state_q;
    mu_d       = mu_q;
    err_mean_d = err_mean_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FILL;
          mu_d    = MU_INIT_V;
        end
      end
      FILL: begin
        if (fill_cnt_q == FILL_LAST) state_d = ADAPT;
      end
      ADAPT: begin
        if (win_end) begin
          err_mean_d = mean_new;
          if (mean_new < TH_LOCK_V) begin
            if (mu_q < MU_MAX_V) mu_d = mu_q + 4'd1;
            else                 state_d = TRACK;
          end
        end
      end
      TRACK: begin
        if (win_end) begin
          err_mean_d = mean_new;
          if (mean_new > TH_UNLOCK_V) begin
            state_d = ADAPT;
            mu_d    = MU_INIT_V;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop_i) begin
      state_d    = IDLE;
      mu_d       = MU_INIT_V;
      err_mean_d = err_mean_q;
    end
  end

  // State, step-size and window-result registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      mu_q       <= MU_INIT_V;
      err_mean_q <= '0;
    end else begin
      state_q    <= state_d;
      mu_q       <= mu_d;
      err_mean_q <= err_mean_d;
    end
  end

  // Valid pipeline mirroring the error calculator latency
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_vld_sr <= '0;
    end else if (state_q == IDLE || stop_i) begin
      err_vld_sr <= '0;
    end else begin
      err_vld_sr <= {err_vld_sr[LAT-2:0], sample_valid_i & filt_en_o};
    end
  end

  // Fill counter: waits out the pipeline latency before updates begin
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fill_cnt_q <= '0;
    end else if (state_q == FILL) begin
      fill_cnt_q <= fill_cnt_q + FILL_W'(1);
    end else begin
      fill_cnt_q <= '0;
    end
  end

  // Window accumulator of |error| and error count
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q     <= '0;
      win_cnt_q <= '0;
    end else if (state_q == IDLE || stop_i || win_end) begin
      acc_q     <= '0;
      win_cnt_q <= '0;
    end else if (acc_en) begin
      acc_q     <= acc_total;
      win_cnt_q <= win_cnt_q + WIN_LOG2'(1);
    end
  end

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// tb_lms_adapt_ctrl: scoreboard bench for lms_adapt_ctrl.
module tb_lms_adapt_ctrl;

  localparam int LAT = 9;

  logic               clk_i = 1'b0;
  logic               rst_n_i;
  logic               start_i;
  logic               stop_i;
  logic               sample_valid_i;
  logic signed [15:0] error_i;
  logic               filt_en_o;
  logic               wupd_en_o;
  logic [3:0]         mu_shift_o;
  logic [15:0]        err_mean_o;
  logic               converged_o;
  logic [1:0]         state_o;

  lms_adapt_ctrl dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .sample_valid_i (sample_valid_i),
    .error_i        (error_i),
    .filt_en_o      (filt_en_o),
    .wupd_en_o      (wupd_en_o),
    .mu_shift_o     (mu_shift_o),
    .err_mean_o     (err_mean_o),
    .converged_o    (converged_o),
    .state_o        (state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int err_val = 0;
  int nerr    = 0;
  int c0      = 0;
  bit exp_run = 1'b0;
  bit end_pend = 1'b0;
  bit end_now  = 1'b0;
  bit win_now  = 1'b0;
  int wq[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Advance one cycle, then compare the update strobe against the scoreboard
  task automatic tick_chk();
    @(posedge clk_i);
    #1;
    cyc++;
    win_now  = end_pend;
    end_pend = 1'b0;
    end_now  = 1'b0;
    if (wq.size() > 0 && wq[0] == cyc) begin
      void'(wq.pop_front());
      chk("wupd", 32'(wupd_en_o), 32'd1);
      nerr++;
      if (nerr % 64 == 0) begin
        end_now  = 1'b1;
        end_pend = 1'b1;
      end
    end else if (wupd_en_o !== 1'b0) begin
      chk("wupd_spurious", 32'(wupd_en_o), 32'd0);
    end
  endtask

  // Drive inputs for the current cycle and push expected update cycles
  task automatic drive(input bit sv, input bit st, input bit sp);
    sample_valid_i = sv;
    start_i        = st;
    stop_i         = sp;
    error_i        = 16'(err_val);
    if (sv && exp_run) wq.push_back(cyc + LAT);
    if (sp) begin
      exp_run  = 1'b0;
      wq.delete();
      nerr     = 0;
      end_pend = 1'b0;
    end else if (st && !exp_run) begin
      exp_run = 1'b1;
    end
  endtask

  task automatic run_window(input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick_chk();
      if (win_now) begin
        ok = 1'b1;
        break;
      end
      drive(1'b1, 1'b0, 1'b0);
    end
    chk("window_timeout", 32'(ok), 32'd1);
  endtask

  task automatic run_to_last(input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick_chk();
      if (end_now) begin
        ok = 1'b1;
        break;
      end
      drive(1'b1, 1'b0, 1'b0);
    end
    chk("last_err_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i = 1'b0;
    start_i = 1'b0;
    stop_i = 1'b0;
    sample_valid_i = 1'b0;
    error_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_filt", 32'(filt_en_o), 32'd0);
    chk("rst_wupd", 32'(wupd_en_o), 32'd0);
    chk("rst_mu", 32'(mu_shift_o), 32'd4);
    chk("rst_mean", 32'(err_mean_o), 32'd0);
    chk("rst_conv", 32'(converged_o), 32'd0);
    rst_n_i = 1'b1;

    // Idle with samples offered but no start
    for (int i = 0; i < 20; i++) begin
      tick_chk();
      drive(1'b1, 1'b0, 1'b0);
    end
    chk("idle_state", 32'(state_o), 32'd0);
    chk("idle_filt", 32'(filt_en_o), 32'd0);
    chk("idle_mu", 32'(mu_shift_o), 32'd4);

    // Start, with a sample every cycle and constant error 100
    err_val = 100;
    tick_chk();
    drive(1'b1, 1'b1, 1'b0);
    c0 = cyc;
    for (int r = 1; r <= 10; r++) begin
      tick_chk();
      if (r == 1) begin
        chk("fill_filt", 32'(filt_en_o), 32'd1);
        chk("fill_state", 32'(state_o), 32'd1);
      end
      if (r == 9)  chk("fill_state_end", 32'(state_o), 32'd1);
      if (r == 10) begin
        chk("adapt_entry", 32'(state_o), 32'd2);
        chk("first_wupd", 32'(wupd_en_o), 32'd1);
      end
      drive(1'b1, 1'b0, 1'b0);
    end

    // Seven windows of mean 100: mu climbs to 10, then lock
    for (int k = 1; k <= 7; k++) begin
      run_window(200);
      chk("win_mean", 32'(err_mean_o), 32'd100);
      chk("win_mu", 32'(mu_shift_o), (4 + k < 10) ? 32'(4 + k) : 32'd10);
      chk("win_state", 32'(state_o), (k == 7) ? 32'd3 : 32'd2);
      chk("win_conv", 32'(converged_o), (k == 7) ? 32'd1 : 32'd0);
      if (k == 7) err_val = -2000;
      drive(1'b1, 1'b0, 1'b0);
    end

    // Large error in TRACK drops back to ADAPT with coarse step
    run_window(200);
    chk("unlock_mean", 32'(err_mean_o), 32'd2000);
    chk("unlock_state", 32'(state_o), 32'd2);
    chk("unlock_mu", 32'(mu_shift_o), 32'd4);
    chk("unlock_conv", 32'(converged_o), 32'd0);
    err_val = -32768;
    drive(1'b1, 1'b1, 1'b0);
    tick_chk();
    chk("start_ignored_state", 32'(state_o), 32'd2);
    chk("start_ignored_mu", 32'(mu_shift_o), 32'd4);
    drive(1'b1, 1'b0, 1'b0);

    // Most negative error saturates; no lock so mu holds
    run_window(200);
    chk("sat_mean", 32'(err_mean_o), 32'd32767);
    chk("sat_mu", 32'(mu_shift_o), 32'd4);
    chk("sat_state", 32'(state_o), 32'd2);
    err_val = 100;
    drive(1'b1, 1'b0, 1'b0);

    // Stop collides with the final error of a locking window
    run_to_last(200);
    drive(1'b1, 1'b0, 1'b1);
    tick_chk();
    chk("stop_state", 32'(state_o), 32'd0);
    chk("stop_mean", 32'(err_mean_o), 32'd32767);
    chk("stop_mu", 32'(mu_shift_o), 32'd4);
    chk("stop_filt", 32'(filt_en_o), 32'd0);
    chk("stop_conv", 32'(converged_o), 32'd0);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick_chk();
      drive(1'b1, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-ADAPT discards in-flight samples
    tick_chk();
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick_chk();
      drive(1'b1, 1'b0, 1'b0);
    end
    chk("pre_rst_state", 32'(state_o), 32'd2);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_mean", 32'(err_mean_o), 32'd0);
    chk("arst_mu", 32'(mu_shift_o), 32'd4);
    chk("arst_wupd", 32'(wupd_en_o), 32'd0);
    exp_run  = 1'b0;
    wq.delete();
    nerr     = 0;
    end_pend = 1'b0;
    tick_chk();
    rst_n_i = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick_chk();
      drive(1'b1, 1'b0, 1'b0);
    end
    chk("post_rst_state", 32'(state_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
